// File: rtl/rv64_fetch_stage.sv
// Instruction-fetch stage: PC generation, single-outstanding req/addr_ok/data_ok bus master,
// one-entry instruction buffer toward stage 1, and redirect handling with in-flight cancel.
module rv64_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          INST_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  output logic                 inst_req,
  output logic [63:0]          inst_addr,
  input  logic                 inst_addr_ok,
  input  logic [INST_W-1:0]    inst_rdata,
  input  logic                 inst_data_ok,
  input  logic                 out_allow,
  output logic                 validout,
  output logic [64+INST_W-1:0] dataout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

  state_t              state;
  logic [63:0]         next_pc;
  logic [63:0]         req_pc;
  logic [63:0]         buf_pc;
  logic [INST_W-1:0]   buf_inst;
  logic                buf_valid;
  logic                cancel;

  logic [63:0]         redirect_aligned;
  logic [63:0]         issue_pc;
  logic                drain;
  logic                can_issue;
  logic                load;

  assign redirect_aligned = redirect_pc & ~64'd3;
  assign issue_pc         = redirect_valid ? redirect_aligned : next_pc;
  assign validout         = buf_valid && !redirect_valid;
  assign drain            = validout && out_allow;
  assign can_issue        = !buf_valid || drain;
  assign load             = (state == S_DATA) && inst_data_ok && !cancel && !redirect_valid;
  assign dataout          = {buf_pc, buf_inst};

  // A redirect is applied last so it overrides both a same-cycle load and the cancel clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      next_pc   <= RESET_PC;
      req_pc    <= '0;
      buf_pc    <= '0;
      buf_inst  <= '0;
      buf_valid <= 1'b0;
      cancel    <= 1'b0;
      inst_req  <= 1'b0;
      inst_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (can_issue) begin
            state     <= S_REQ;
            req_pc    <= issue_pc;
            inst_req  <= 1'b1;
            inst_addr <= issue_pc;
          end
        end
        S_REQ: begin
          if (inst_addr_ok) begin
            state     <= S_DATA;
            inst_req  <= 1'b0;
            inst_addr <= '0;
          end
        end
        S_DATA: begin
          if (inst_data_ok) begin
            state <= S_IDLE;
            if (!load) cancel <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          inst_req  <= 1'b0;
          inst_addr <= '0;
        end
      endcase

      if (load) begin
        buf_pc    <= req_pc;
        buf_inst  <= inst_rdata;
        buf_valid <= 1'b1;
        next_pc   <= req_pc + 64'd4;
      end else if (drain) begin
        buf_valid <= 1'b0;
      end

      if (redirect_valid) begin
        next_pc   <= redirect_aligned;
        buf_valid <= 1'b0;
        if (state == S_REQ || (state == S_DATA && !inst_data_ok))
          cancel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv64_fetch_stage.sv
// Bench for rv64_fetch_stage: behavioural bus slave, directed tests, and a scoreboard monitor
// checking request addresses and stage-1 transfers against queues of expected values.
module tb_rv64_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_req;
  logic [63:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        inst_data_ok = 1'b0;
  logic        out_allow = 1'b1;
  logic        validout;
  logic [95:0] dataout;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int xfer_count = 0;
  int xfer_cyc[$];
  bit saw_dead = 1'b0;

  logic [63:0] exp_addr[$];
  logic [95:0] exp_xfer[$];

  int addr_delay = 0;
  int data_delay = 0;
  bit dead_mode = 1'b0;

  rv64_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_rdata     (inst_rdata),
    .inst_data_ok   (inst_data_ok),
    .out_allow      (out_allow),
    .validout       (validout),
    .dataout        (dataout)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom(input logic [63:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Slave decides its outputs mid-cycle, so they are stable across the next posedge.
  int          a_cnt = 0;
  int          d_cnt = 0;
  bit          pending = 1'b0;
  logic [63:0] pend_addr = '0;
  always @(negedge clk) begin
    if (rst) begin
      pending      = 1'b0;
      a_cnt        = 0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
    end else begin
      if (inst_data_ok) pending = 1'b0;
      if (inst_addr_ok) begin
        pending = 1'b1;
        d_cnt   = data_delay;
      end
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      if (pending) begin
        if (d_cnt == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = dead_mode ? 32'h0000_DEAD : rom(pend_addr);
        end else begin
          d_cnt--;
        end
      end else if (inst_req) begin
        if (a_cnt >= addr_delay) begin
          inst_addr_ok = 1'b1;
          pend_addr    = inst_addr;
          a_cnt        = 0;
        end else begin
          a_cnt++;
        end
      end
    end
  end

  // Scoreboard monitor: pops the expected value whenever a handshake is presented.
  always @(negedge clk) begin
    logic [63:0] ea;
    logic [95:0] ex;
    #1;
    if (!rst) begin
      if (inst_req && inst_addr_ok) begin
        if (exp_addr.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_req: got addr %h, expected no request", inst_addr);
        end else begin
          ea = exp_addr.pop_front();
          check_output("req_addr", {64'd0, inst_addr}, {64'd0, ea});
        end
      end
      if (validout && out_allow) begin
        xfer_count++;
        xfer_cyc.push_back(cyc);
        if (exp_xfer.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_xfer: got %h, expected no transfer", dataout);
        end else begin
          ex = exp_xfer.pop_front();
          check_output("xfer", {32'd0, dataout}, {32'd0, ex});
        end
      end
      if (validout && dataout[31:0] == 32'h0000_DEAD) saw_dead = 1'b1;
    end
  end

  task automatic apply_stimulus(input int a_dly, input int d_dly, input bit allow);
    @(posedge clk); #1;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    addr_delay     = a_dly;
    data_delay     = d_dly;
    out_allow      = allow;
    dead_mode      = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #2;
    check_output("reset_outputs", {29'd0, inst_req, inst_addr, validout, dataout}, 128'd0);
    xfer_cyc.delete();
    exp_addr.delete();
    exp_xfer.delete();
    @(posedge clk); #1;
    rst     = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_xfers(input int target, input string name);
    int n = 0;
    while (xfer_count < target && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check_output({name, "_xfer_timeout"}, 128'(xfer_count >= target), 128'd1);
  endtask

  task automatic wait_handshake(input string name);
    int n = 0;
    @(negedge clk); #2;
    while (!(inst_req && inst_addr_ok) && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    check_output({name, "_req_timeout"}, 128'(inst_req && inst_addr_ok), 128'd1);
  endtask

  task automatic wait_validout(input string name);
    int n = 0;
    @(negedge clk); #2;
    while (!validout && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    check_output({name, "_valid_timeout"}, 128'(validout), 128'd1);
  endtask

  task automatic end_test(input string name);
    @(posedge clk); #1;
    rst = 1'b1;
    check_output({name, "_exp_addr_left"}, 128'(exp_addr.size()), 128'd0);
    check_output({name, "_exp_xfer_left"}, 128'(exp_xfer.size()), 128'd0);
  endtask

  initial begin
    int base;
    logic [95:0] held;

    // 1: zero-wait slave, three fetches back to back
    apply_stimulus(0, 0, 1'b1);
    base = xfer_count;
    exp_addr.push_back(64'h8000_0000);
    exp_addr.push_back(64'h8000_0004);
    exp_addr.push_back(64'h8000_0008);
    exp_xfer.push_back({64'h8000_0000, 32'h0000_C0DE});
    exp_xfer.push_back({64'h8000_0004, 32'h0004_C0DE});
    exp_xfer.push_back({64'h8000_0008, 32'h0008_C0DE});
    wait_xfers(base + 3, "t1");
    if (xfer_cyc.size() >= 2) begin
      check_output("t1_first_latency", 128'(xfer_cyc[0] - rel_cyc), 128'd3);
      check_output("t1_throughput", 128'(xfer_cyc[1] - xfer_cyc[0]), 128'd3);
    end
    end_test("t1");

    // 2: addr_ok delayed three cycles, request held stable
    apply_stimulus(3, 0, 1'b1);
    base = xfer_count;
    exp_addr.push_back(64'h8000_0000);
    exp_xfer.push_back({64'h8000_0000, 32'h0000_C0DE});
    @(negedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      check_output("t2_req_held", {63'd0, inst_req, inst_addr}, {63'd0, 1'b1, 64'h8000_0000});
    end
    wait_xfers(base + 1, "t2");
    end_test("t2");

    // 3: stage 1 stalls with the buffer full
    apply_stimulus(0, 0, 1'b0);
    base = xfer_count;
    exp_addr.push_back(64'h8000_0000);
    exp_addr.push_back(64'h8000_0004);
    exp_xfer.push_back({64'h8000_0000, 32'h0000_C0DE});
    exp_xfer.push_back({64'h8000_0004, 32'h0004_C0DE});
    wait_validout("t3");
    held = {64'h8000_0000, 32'h0000_C0DE};
    for (int i = 0; i < 10; i++) begin
      check_output("t3_stall", {30'd0, validout, inst_req, dataout}, {30'd0, 1'b1, 1'b0, held});
      @(negedge clk); #2;
    end
    @(posedge clk); #1;
    out_allow = 1'b1;
    wait_xfers(base + 2, "t3");
    end_test("t3");

    // 4: redirect while waiting for data, stale response must vanish
    apply_stimulus(0, 1, 1'b1);
    base      = xfer_count;
    dead_mode = 1'b1;
    saw_dead  = 1'b0;
    exp_addr.push_back(64'h8000_0000);
    exp_addr.push_back(64'h0000_1000);
    exp_xfer.push_back({64'h0000_1000, 32'h1000_C0DE});
    wait_handshake("t4");
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_1000;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    dead_mode = 1'b0;
    wait_xfers(base + 1, "t4");
    check_output("t4_dead_seen", 128'(saw_dead), 128'd0);
    end_test("t4");

    // 5a: redirect coincides with data_ok, unaligned target
    apply_stimulus(0, 0, 1'b1);
    base = xfer_count;
    exp_addr.push_back(64'h8000_0000);
    exp_addr.push_back(64'h0000_2000);
    exp_xfer.push_back({64'h0000_2000, 32'h2000_C0DE});
    wait_handshake("t5a");
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_2002;
    @(negedge clk); #2;
    check_output("t5a_redirect_cycle", {126'd0, validout, inst_data_ok}, {126'd0, 2'b01});
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_xfers(base + 1, "t5a");
    end_test("t5a");

    // 5b: redirect while the buffer holds a stalled instruction
    apply_stimulus(0, 0, 1'b0);
    base = xfer_count;
    exp_addr.push_back(64'h8000_0000);
    exp_addr.push_back(64'h0000_2000);
    exp_xfer.push_back({64'h0000_2000, 32'h2000_C0DE});
    wait_validout("t5b");
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_2002;
    @(negedge clk); #2;
    check_output("t5b_validout_gated", 128'(validout), 128'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    out_allow      = 1'b1;
    wait_xfers(base + 1, "t5b");
    end_test("t5b");

    // 6: PC wraps past the top of the address space
    apply_stimulus(0, 0, 1'b1);
    base           = xfer_count;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_addr.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_addr.push_back(64'h0000_0000_0000_0000);
    exp_xfer.push_back({64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFC_C0DE});
    exp_xfer.push_back({64'h0000_0000_0000_0000, 32'h0000_C0DE});
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_xfers(base + 2, "t6");
    end_test("t6");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
